// File: rtl/seq_alu_pkg.sv
// Shared types and defaults for the seq_alu execute stage.
// Opcode encoding matches the 3-bit Op field driven by the decoder.
package seq_alu_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int SHAMT_W_DEF = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_AND  = 3'b001,
    OP_NOT  = 3'b010,
    OP_PASS = 3'b011,
    OP_MUL  = 3'b100,
    OP_MULH = 3'b101,
    OP_SLL  = 3'b110,
    OP_SRA  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iter(input op_t op);
    return op inside {OP_MUL, OP_MULH, OP_SLL, OP_SRA};
  endfunction

  function automatic logic is_shift(input op_t op);
    return op inside {OP_SLL, OP_SRA};
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request / write-back bundle between the register file side and seq_alu.
// The master issues requests; the slave (seq_alu) returns the write-back.
interface seq_alu_if #(
  parameter int WIDTH = seq_alu_pkg::WIDTH_DEF
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       DR_In;
  logic             Busy;
  logic             Done;
  logic             Wr_En;
  logic [2:0]       Wr_DR;
  logic [WIDTH-1:0] Wr_Data;
  logic             N;
  logic             Z;
  logic             P;

  modport master (
    output Start, Op, A, B, DR_In,
    input  Busy, Done, Wr_En, Wr_DR, Wr_Data, N, Z, P
  );

  modport slave (
    input  Start, Op, A, B, DR_In,
    output Busy, Done, Wr_En, Wr_DR, Wr_Data, N, Z, P
  );
endinterface

// File: rtl/seq_alu_mul_shift_core.sv
// Iterative datapath: shift-add unsigned multiplier and one-bit-per-cycle shifter.
// Exposes next-step values so the FSM can capture the final result on the last step.
module mul_shift_core
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  op_t                op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0]   sreg_nxt,
  output logic               cnt_zero
);

  localparam int CNT_W = SHAMT_W + 1;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] mcand_nxt;
  logic [WIDTH-1:0]   sreg;
  logic [CNT_W-1:0]   cnt;

  // The counter reaches zero as a result of the current step.
  assign cnt_zero = (cnt == CNT_W'(1));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    acc_nxt   = acc;
    mcand_nxt = mcand;
    sreg_nxt  = sreg;
    case (op)
      OP_MUL, OP_MULH: begin
        if (sreg[0]) acc_nxt = acc + mcand;
        mcand_nxt = mcand << 1;
        sreg_nxt  = sreg >> 1;
      end
      OP_SLL:  sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
      OP_SRA:  sreg_nxt = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: datapath registers are reset too, so the block comes up in a known state.
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      sreg  <= '0;
      cnt   <= '0;
    end else if (load) begin
      case (op)
        OP_MUL, OP_MULH: begin
          acc   <= '0;
          mcand <= {{WIDTH{1'b0}}, a};
          sreg  <= b;
          cnt   <= CNT_W'(WIDTH);
        end
        OP_SLL, OP_SRA: begin
          sreg <= a;
          cnt  <= {1'b0, b[SHAMT_W-1:0]};
        end
        default: ;
      endcase
    end else if (step) begin
      // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
      acc   <= acc_nxt;
      mcand <= mcand_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute stage: FSM, single-cycle ops and NZP condition codes.
// Iterative ops run in mul_shift_core; write-back is a one-cycle Wr_En pulse.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF
) (
  input logic     Clk,
  input logic     Reset,
  seq_alu_if.slave bus
);

  state_t             state;
  op_t                op_q;
  logic [2:0]         dr_q;
  op_t                op_in;
  op_t                core_op;
  logic               load;
  logic               step;
  logic               iter_go;
  logic               fin_go;
  logic               cnt_zero;
  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   sreg_nxt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   iter_res;
  logic [WIDTH-1:0]   fin_data;
  logic [2:0]         fin_dr;

  function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v == '0, !v[WIDTH-1] && (v != '0)};
  endfunction

  assign op_in   = op_t'(bus.Op);
  assign core_op = (state == IDLE) ? op_in : op_q;
  // A zero shift amount completes straight from IDLE with result = A.
  assign iter_go = is_iter(op_in) && !(is_shift(op_in) && (bus.B[SHAMT_W-1:0] == '0));
  assign load    = (state == IDLE) && bus.Start && is_iter(op_in);
  assign step    = (state == RUN);
  assign fin_go  = ((state == IDLE) && bus.Start && !iter_go) ||
                   ((state == RUN) && cnt_zero);

  always_comb begin
    alu_res = bus.A;
    case (op_in)
      OP_ADD:  alu_res = bus.A + bus.B;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_NOT:  alu_res = ~bus.A;
      default: alu_res = bus.A;
    endcase
  end

  always_comb begin
    iter_res = sreg_nxt;
    case (op_q)
      OP_MUL:  iter_res = acc_nxt[WIDTH-1:0];
      OP_MULH: iter_res = acc_nxt[2*WIDTH-1:WIDTH];
      default: iter_res = sreg_nxt;
    endcase
  end

  assign fin_data = (state == RUN) ? iter_res : alu_res;
  assign fin_dr   = (state == RUN) ? dr_q : bus.DR_In;

  mul_shift_core #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_core (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (load),
    .step     (step),
    .op       (core_op),
    .a        (bus.A),
    .b        (bus.B),
    .acc_nxt  (acc_nxt),
    .sreg_nxt (sreg_nxt),
    .cnt_zero (cnt_zero)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      op_q        <= OP_ADD;
      dr_q        <= '0;
      bus.Busy    <= 1'b0;
      bus.Done    <= 1'b0;
      bus.Wr_En   <= 1'b0;
      bus.Wr_DR   <= '0;
      bus.Wr_Data <= '0;
      bus.N       <= 1'b0;
      bus.Z       <= 1'b1;
      bus.P       <= 1'b0;
    end else begin
      bus.Done  <= 1'b0;
      bus.Wr_En <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            op_q     <= op_in;
            dr_q     <= bus.DR_In;
            bus.Busy <= 1'b1;
            if (iter_go) state <= RUN;
          end
        end
        RUN: ;
        DONE: begin
          state    <= IDLE;
          bus.Busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (fin_go) begin
        state                 <= DONE;
        bus.Done              <= 1'b1;
        bus.Wr_En             <= 1'b1;
        bus.Wr_DR             <= fin_dr;
        bus.Wr_Data           <= fin_data;
        {bus.N, bus.Z, bus.P} <= nzp_of(fin_data);
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: arithmetic reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_seq_alu;

  localparam int LIM = 40;

  logic Clk = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;
  bit   cmp_en = 1'b0;

  seq_alu_if #(.WIDTH(16)) bus ();

  seq_alu #(.WIDTH(16), .SHAMT_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: result and latency straight from the operation definitions.
  function automatic logic [15:0] model_res(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [31:0] prod;
    logic [3:0]  sh;
    prod = {16'h0, a} * {16'h0, b};
    sh   = b[3:0];
    case (op)
      3'd0: return a + b;
      3'd1: return a & b;
      3'd2: return ~a;
      3'd3: return a;
      3'd4: return prod[15:0];
      3'd5: return prod[31:16];
      3'd6: return a << sh;
      default: return 16'($signed(a) >>> sh);
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [15:0] b);
    if (op < 3'd4) return 1;
    if (op < 3'd6) return 17;
    return int'(b[3:0]) + 1;
  endfunction

  function automatic logic [2:0] model_nzp(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  int          m_left;
  logic [15:0] m_pend;
  logic [2:0]  m_pend_dr;
  logic [15:0] m_wd;
  logic [2:0]  m_dr;
  logic [2:0]  m_nzp;

  // m_left counts the remaining busy cycles of the accepted request.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_left = 0;
      m_wd   = 16'h0;
      m_dr   = 3'h0;
      m_nzp  = 3'b010;
    end else begin
      if (m_left > 0) m_left--;
      else if (bus.Start) begin
        m_left    = model_lat(bus.Op, bus.B);
        m_pend    = model_res(bus.Op, bus.A, bus.B);
        m_pend_dr = bus.DR_In;
      end
      if (m_left == 1) begin
        m_wd  = m_pend;
        m_dr  = m_pend_dr;
        m_nzp = model_nzp(m_pend);
      end
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      check("busy",    32'(bus.Busy),  32'(m_left > 0));
      check("done",    32'(bus.Done),  32'(m_left == 1));
      check("wr_en",   32'(bus.Wr_En), 32'(m_left == 1));
      check("wr_dr",   32'(bus.Wr_DR), 32'(m_dr));
      check("wr_data", 32'(bus.Wr_Data), 32'(m_wd));
      check("nzp",     32'({bus.N, bus.Z, bus.P}), 32'(m_nzp));
    end
  end

  // Called at a negedge; returns at the negedge where Done is visible.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] dr, output int lat);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    bus.DR_In = dr;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.A     = 16'hDEAD;
    bus.B     = 16'hBEEF;
    bus.DR_In = 3'd7;
    lat = 1;
    while (!bus.Done && lat < LIM) begin
      @(negedge Clk);
      lat++;
    end
    check("done_seen", 32'(bus.Done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int busy_n;
    int done_n;
    int wr_n;
    logic [15:0] wd_cap;

    Reset     = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 3'd0;
    bus.A     = 16'h0;
    bus.B     = 16'h0;
    bus.DR_In = 3'd0;
    repeat (3) @(negedge Clk);
    check("rst_busy",    32'(bus.Busy),    32'd0);
    check("rst_done",    32'(bus.Done),    32'd0);
    check("rst_wr_en",   32'(bus.Wr_En),   32'd0);
    check("rst_wr_data", 32'(bus.Wr_Data), 32'd0);
    check("rst_wr_dr",   32'(bus.Wr_DR),   32'd0);
    check("rst_nzp",     32'({bus.N, bus.Z, bus.P}), 32'b010);
    Reset  = 1'b1;
    cmp_en = 1'b1;
    @(negedge Clk);

    run_op(3'd0, 16'h7FFF, 16'h0001, 3'd3, lat);
    check("add_lat",  32'(lat), 32'd1);
    check("add_data", 32'(bus.Wr_Data), 32'h8000);
    check("add_dr",   32'(bus.Wr_DR), 32'd3);
    check("add_nzp",  32'({bus.N, bus.Z, bus.P}), 32'b100);
    @(negedge Clk);

    run_op(3'd1, 16'hF0F0, 16'h0F0F, 3'd5, lat);
    check("and_data", 32'(bus.Wr_Data), 32'h0);
    check("and_nzp",  32'({bus.N, bus.Z, bus.P}), 32'b010);
    @(negedge Clk);

    run_op(3'd0, 16'hFFFF, 16'h0002, 3'd2, lat);
    check("add_wrap", 32'(bus.Wr_Data), 32'h0001);
    @(negedge Clk);

    run_op(3'd4, 16'd300, 16'd500, 3'd1, lat);
    check("mul_lat",  32'(lat), 32'd17);
    check("mul_data", 32'(bus.Wr_Data), 32'h49F0);
    @(negedge Clk);

    run_op(3'd5, 16'd300, 16'd500, 3'd6, lat);
    check("mulh_lat",  32'(lat), 32'd17);
    check("mulh_data", 32'(bus.Wr_Data), 32'h0002);
    check("mulh_nzp",  32'({bus.N, bus.Z, bus.P}), 32'b001);
    @(negedge Clk);

    run_op(3'd5, 16'hFFFF, 16'hFFFF, 3'd4, lat);
    check("mulh_max", 32'(bus.Wr_Data), 32'hFFFE);
    @(negedge Clk);

    run_op(3'd7, 16'h8000, 16'd4, 3'd2, lat);
    check("sra_lat",  32'(lat), 32'd5);
    check("sra_data", 32'(bus.Wr_Data), 32'hF800);
    @(negedge Clk);

    run_op(3'd6, 16'h00FF, 16'h001F, 3'd0, lat);
    check("sll15_lat",  32'(lat), 32'd16);
    check("sll15_data", 32'(bus.Wr_Data), 32'h8000);
    @(negedge Clk);

    run_op(3'd6, 16'h0001, 16'h0000, 3'd7, lat);
    check("sll0_lat",  32'(lat), 32'd1);
    check("sll0_data", 32'(bus.Wr_Data), 32'h0001);
    @(negedge Clk);

    // Back-to-back: request on the first IDLE cycle after Done.
    run_op(3'd2, 16'h0000, 16'h0000, 3'd5, lat);
    check("not_lat",  32'(lat), 32'd1);
    check("not_data", 32'(bus.Wr_Data), 32'hFFFF);
    check("not_nzp",  32'({bus.N, bus.Z, bus.P}), 32'b100);
    @(negedge Clk);
    check("not_wr_en_once", 32'(bus.Wr_En), 32'd0);

    // Start held high with changing operands during a MUL and its DONE cycle.
    bus.Start = 1'b1;
    bus.Op    = 3'd4;
    bus.A     = 16'd300;
    bus.B     = 16'd500;
    bus.DR_In = 3'd1;
    busy_n = 0;
    done_n = 0;
    wd_cap = 16'h0;
    for (int i = 1; i <= 17; i++) begin
      @(negedge Clk);
      if (bus.Busy) busy_n++;
      if (bus.Wr_En) begin
        done_n++;
        wd_cap = bus.Wr_Data;
      end
      bus.Op    = 3'(i % 4);
      bus.A     = 16'(i);
      bus.B     = 16'h1234;
      bus.DR_In = 3'(i);
    end
    @(negedge Clk);
    bus.Start = 1'b0;
    check("busy_cycles", 32'(busy_n), 32'd17);
    check("busy_dones",  32'(done_n), 32'd1);
    check("busy_data",   32'(wd_cap), 32'h49F0);
    check("busy_idle",   32'(bus.Busy), 32'd0);
    @(negedge Clk);

    // Reset during a MUL aborts it with no write-back.
    bus.Start = 1'b1;
    bus.Op    = 3'd4;
    bus.A     = 16'd300;
    bus.B     = 16'd500;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (4) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.Busy), 32'd0);
    check("midrst_nzp",  32'({bus.N, bus.Z, bus.P}), 32'b010);
    check("midrst_wr_en", 32'(bus.Wr_En), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    wr_n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (bus.Wr_En) wr_n++;
    end
    check("midrst_no_wb", 32'(wr_n), 32'd0);

    run_op(3'd0, 16'd7, 16'd5, 3'd2, lat);
    check("postrst_data", 32'(bus.Wr_Data), 32'd12);
    check("postrst_lat",  32'(lat), 32'd1);
    @(negedge Clk);
    @(negedge Clk);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle execute stage directly downstream of the 8x16 register file.
- Consumes the SR1/SR2 read ports and a destination register index, then computes one of eight operations.
- Single-cycle ops: ADD, AND, NOT, PASS. Iterative ops: MUL low, MUL high, SLL, SRA.
- Returns a one-cycle write-back request (Wr_En, Wr_DR, Wr_Data) that drives the register file's LD_REG/DR/Data_In, and maintains the NZP condition codes.

Parameters:
- WIDTH, 16, operand/result width.
- SHAMT_W, 4, shift-amount width; must equal log2(WIDTH).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Op  in  3  opcode: 000 ADD, 001 AND, 010 NOT A, 011 PASS A, 100 MUL (low WIDTH bits), 101 MULH (high WIDTH bits), 110 SLL, 111 SRA.
- A  in  WIDTH  operand from SR1_Out.
- B  in  WIDTH  operand from SR2_Out or immediate.
- DR_In  in  3  destination register index.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle completion pulse.
- Wr_En  out  1  equals Done; drives LD_REG.
- Wr_DR  out  3  captured DR_In.
- Wr_Data  out  WIDTH  result; drives Data_In.
- N, Z, P  out  1 each  condition codes.

Behaviour:
- Reset (Reset=0, asynchronous):
  - state=IDLE; Busy=0, Done=0, Wr_En=0.
  - Wr_DR=0, Wr_Data=0, counter=0.
  - N=0, Z=1, P=0.
  - Reset mid-operation aborts the operation; no write-back is issued.
- States: IDLE, RUN, DONE.
- IDLE:
  - On Start=1 at a rising edge, capture Op, A, B, DR_In.
  - ADD/AND/NOT/PASS: compute and register the result, go to DONE.
  - MUL/MULH: accumulator=0, multiplicand=A zero-extended to 2*WIDTH, multiplier=B, counter=WIDTH, go to RUN.
  - SLL/SRA: counter=B[SHAMT_W-1:0]. If counter=0, result=A and go to DONE; otherwise go to RUN.
- RUN (one step per cycle; counter decrements; at counter reaching 0 go to DONE):
  - MUL/MULH: if multiplier[0], accumulator += multiplicand; then multiplicand <<= 1, multiplier >>= 1.
  - SLL: result <<= 1, zero fill.
  - SRA: result >>= 1, sign fill.
- DONE (exactly one cycle, then IDLE):
  - Done=1 and Wr_En=1.
  - Wr_Data = result (MUL: acc[WIDTH-1:0]; MULH: acc[2*WIDTH-1:WIDTH]).
  - N/Z/P updated from Wr_Data as signed: exactly one of them is high.
- Latency, with Start sampled at edge 0:
  - Single-cycle ops: Done high after edge 1.
  - MUL/MULH: Done high after edge WIDTH+1 (edge 17 at the defaults).
  - Shift by n: Done high after edge n+1.
- Arithmetic: ADD wraps modulo 2^WIDTH; no carry/overflow output. MUL/MULH are unsigned.
- Start while Busy=1 is ignored, including in the DONE cycle. Start must be held or re-issued in IDLE.
- Operand inputs may change after capture without effect on the result.
- Wr_DR and Wr_Data hold their last values while in IDLE; consumers qualify them with Wr_En.
- N/Z/P change only in the DONE cycle.

Decomposition:
- Package seq_alu_pkg:
  - op_t enum: OP_ADD, OP_AND, OP_NOT, OP_PASS, OP_MUL, OP_MULH, OP_SLL, OP_SRA.
  - state_t enum: IDLE, RUN, DONE.
  - localparams WIDTH_DEF=16, SHAMT_W_DEF=4.
- One sub-module, mul_shift_core: the iterative datapath (accumulator, multiplicand, multiplier/shift register, counter), with load/step inputs and a zero-count output. seq_alu keeps the FSM, the single-cycle ops and NZP.

Test Plan:
- Reset checks: Reset low mid-MUL (cycle 5) -> Busy=0 and NZP=010 immediately; no Wr_En pulse follows. After Reset release, ADD A=7, B=5 -> Wr_Data=12.
- ADD and AND:
  - ADD A=16'h7FFF, B=1, DR_In=3 -> Done one cycle later; Wr_Data=16'h8000, Wr_DR=3, N=1.
  - AND A=16'hF0F0, B=16'h0F0F -> Wr_Data=0, Z=1.
- Multiply: MUL A=300, B=500 -> Done exactly 17 cycles after Start; Wr_Data=16'h49F0. MULH with the same operands -> Wr_Data=16'h0002, P=1.
- Shifts:
  - SRA A=16'h8000, B=4 -> Done after 5 cycles; Wr_Data=16'hF800.
  - SLL A=1, B=0 -> Done after 1 cycle; Wr_Data=1.
- Busy handling: Start pulses every cycle during a MUL, with different operands -> only the first is accepted. Exactly one Done/Wr_En pulse follows, and Busy is high for exactly 17 cycles.
- Back-to-back: assert Start on the first IDLE cycle after Done, with NOT A=0 -> Wr_Data=16'hFFFF, N=1, Wr_En high for one cycle only.
